stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Run/pause/adjust controller for the four-digit mm:ss stopwatch. It owns the BCD minute and second registers and advances them from the divided 1 Hz and 2 Hz strobes. It applies the debounced pause pulse and the select/adjust switches, and hands the display multiplexer four BCD digits plus per-digit blink qualifiers. It sits between the debouncers/clock divider and the seven-segment scan logic.

## Interface
- `MAX_MIN`, default 59: highest minute value before wrap to 00.
- `MAX_SEC`, default 59: highest second value before wrap to 00.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tick_1hz`  in  1  one-`clk`-wide strobe at 1 Hz; advances time when running.
- `tick_2hz`  in  1  one-`clk`-wide strobe at 2 Hz; adjust increment and blink phase.
- `pause_pulse`  in  1  one-`clk`-wide pulse from the pause debouncer; toggles run/pause.
- `sel`  in  1  adjust target: 0 = minutes, 1 = seconds (level).
- `adj`  in  1  adjust mode enable (level).
- `min_1`, `min_0`, `sec_1`, `sec_0`  out  4 each  BCD digits, tens then units.
- `blank`  out  4  per-digit blank request, bit3 = `min_1` … bit0 = `sec_0`.
- `running`  out  1  high while the state is RUN.

## Operation
- States: RUN, PAUSED, ADJUST. The `paused_saved` flag records the state to resume after ADJUST.
- Reset values: state RUN, all digits 0, `blank` = 4'b0000, `running` = 1, `paused_saved` = 0, blink phase = 0.
- RUN:
  - `tick_1hz` increments the seconds field.
  - At `MAX_SEC`, seconds wrap to 00 and minutes increment.
  - At `MAX_MIN`:`MAX_SEC`, all digits wrap to 00:00.
  - `pause_pulse` → PAUSED.
- PAUSED:
  - Digits hold.
  - `pause_pulse` → RUN.
  - `tick_1hz` is ignored.
- Entry to ADJUST: `adj` = 1 in RUN or PAUSED → ADJUST, with `paused_saved` = (state == PAUSED).
- ADJUST:
  - `tick_1hz` is ignored.
  - `tick_2hz` increments only the field chosen by `sel`.
  - The adjusted field wraps `MAX`→00 with no carry into the other field.
  - `pause_pulse` toggles `paused_saved` only.
  - `adj` = 0 → PAUSED if `paused_saved`, else RUN.
- Blink:
  - The blink phase toggles on each `tick_2hz` in ADJUST and is cleared on exit from ADJUST.
  - In ADJUST with phase = 1, `blank` = 4'b1100 (sel = 0) or 4'b0011 (sel = 1).
  - Otherwise `blank` = 4'b0000.
- Arithmetic:
  - Each field is a two-digit BCD counter.
  - Units roll 9→0 with carry to tens.
  - The wrap compare uses the full 8-bit field against the BCD encoding of `MAX`.
  - Digits never leave 0–9.

## Timing
- All outputs are registered.
- A digit change appears one cycle after the qualifying strobe edge.
- `running` and `blank` update in the same cycle as the state change.
- Simultaneous events in one cycle:
  - `rst` overrides everything.
  - `tick_1hz` with `pause_pulse` in RUN: the increment happens, then the state becomes PAUSED.
  - `tick_1hz` with `pause_pulse` in PAUSED: no increment, then the state becomes RUN.
  - `adj` rising with `tick_1hz` in RUN: the increment happens, then the state becomes ADJUST.
  - `adj` rising with `tick_2hz`: no adjust increment until the next `tick_2hz`.
  - `adj` = 1 with `pause_pulse` in RUN or PAUSED: the pulse is applied first, so `paused_saved` takes the post-toggle state.
- A change of `sel` in ADJUST takes effect on the next cycle's `blank` and on the next `tick_2hz`.
- A mid-operation `rst` during ADJUST returns to RUN at 00:00 on the following cycle.
- Strobes wider than one cycle are illegal inputs. Each high cycle counts as one event.

## Structure
- `stopwatch_pkg` holds:
  - the state encoding (RUN = 2'd0, PAUSED = 2'd1, ADJUST = 2'd2);
  - the digit-index constants;
  - `BLANK_MIN` = 4'b1100 and `BLANK_SEC` = 4'b0011.
- Sub-module `bcd_mod_counter`:
  - parameter `MAX`;
  - ports `clk`, `rst`, `inc`, `tens[3:0]`, `ones[3:0]`, `wrap`, where `wrap` is combinational and high when `inc` and at `MAX`.
  - It is instantiated twice (minutes, seconds).
- The top-level FSM generates the `inc` qualifiers and carry gating.

## Test plan
- Reset, then 65 `tick_1hz` strobes → digits 0,1,0,5, with `running` = 1 throughout.
- Preload-by-ticks to 59:59, then one `tick_1hz` → 00:00 on the next cycle, with no stray carry.
- `pause_pulse` at 00:03, then 10 `tick_1hz` → digits hold at 00:03 and `running` = 0. A second `pause_pulse` resumes, and 2 ticks give 00:05.
- `adj` = 1, `sel` = 1 at 00:58, then 3 `tick_2hz` → 00:01 with minutes unchanged. `blank` alternates 4'b0011/4'b0000 per `tick_2hz`. `adj` = 0 → RUN, `blank` = 0.
- PAUSED at 12:00, `adj` = 1 with `sel` = 0, plus one `pause_pulse` in ADJUST, then 1 `tick_2hz` → 13:00. `adj` = 0 → RUN.
- Same-cycle `tick_1hz` + `pause_pulse` in RUN at 00:09 → 00:10 and PAUSED. `rst` asserted during ADJUST → 00:00, RUN, `blank` = 0 one cycle later.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the mm:ss stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSED = 2'd1,
    ST_ADJUST = 2'd2
  } state_t;

  // Digit positions, matching the bit order of the blank vector.
  localparam int DIG_SEC_0 = 0;
  localparam int DIG_SEC_1 = 1;
  localparam int DIG_MIN_0 = 2;
  localparam int DIG_MIN_1 = 3;

  localparam logic [3:0] BLANK_MIN = 4'b1100;
  localparam logic [3:0] BLANK_SEC = 4'b0011;

  function automatic logic [7:0] to_bcd8(input int value);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(value / 10);
    ones = 4'(value % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Bundle of strobes, switches and display outputs between the controller and its neighbours.
interface stopwatch_if;
  import stopwatch_pkg::*;

  // Strobes are one-cycle events with no backpressure: the controller acts on every
  // cycle in which a strobe is high, and there is no ready/acknowledge path back.
  logic       tick_1hz;
  logic       tick_2hz;
  logic       pause_pulse;
  logic       sel;
  logic       adj;
  logic [3:0] min_1;
  logic [3:0] min_0;
  logic [3:0] sec_1;
  logic [3:0] sec_0;
  logic [3:0] blank;
  logic       running;
  state_t     state;

  modport master (
    output tick_1hz, tick_2hz, pause_pulse, sel, adj,
    input  min_1, min_0, sec_1, sec_0, blank, running, state
  );

  modport slave (
    input  tick_1hz, tick_2hz, pause_pulse, sel, adj,
    output min_1, min_0, sec_1, sec_0, blank, running, state
  );

endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter that wraps from MAX to 00; wrap flags the carry-out event.
module bcd_mod_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       wrap
);

  localparam logic [7:0] MAX_BCD = to_bcd8(MAX);

  logic at_max;

  assign at_max = ({tens, ones} == MAX_BCD);
  assign wrap   = inc && at_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      tens <= 4'd0;
      ones <= 4'd0;
    end else if (inc) begin
      if (at_max) begin
        tens <= 4'd0;
        ones <= 4'd0;
      end else if (ones == 4'd9) begin
        tens <= tens + 4'd1;
        ones <= 4'd0;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/adjust controller: owns the mm:ss BCD registers and per-digit blink requests.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN = 59,
  parameter int MAX_SEC = 59
) (
  input  logic        clk,
  input  logic        rst,
  stopwatch_if.slave  sw
);

  state_t state;
  state_t state_nxt;
  logic   paused_saved;
  logic   saved_nxt;
  logic   phase;
  logic   phase_nxt;
  logic   sec_inc;
  logic   min_inc;
  logic   sec_wrap;
  logic   min_wrap;

  // Seconds wrap only carries into minutes while running; adjust edits one field in isolation.
  assign sec_inc = ((state == ST_RUN) && sw.tick_1hz) ||
                   ((state == ST_ADJUST) && sw.tick_2hz && sw.sel);
  assign min_inc = ((state == ST_RUN) && sec_wrap) ||
                   ((state == ST_ADJUST) && sw.tick_2hz && !sw.sel);

  bcd_mod_counter #(.MAX(MAX_SEC)) u_sec (
    .clk  (clk),
    .rst  (rst),
    .inc  (sec_inc),
    .tens (sw.sec_1),
    .ones (sw.sec_0),
    .wrap (sec_wrap)
  );

  bcd_mod_counter #(.MAX(MAX_MIN)) u_min (
    .clk  (clk),
    .rst  (rst),
    .inc  (min_inc),
    .tens (sw.min_1),
    .ones (sw.min_0),
    .wrap (min_wrap)
  );

  always_comb begin
    state_nxt = state;
    saved_nxt = paused_saved;
    phase_nxt = phase;
    case (state)
      ST_RUN: begin
        // A same-cycle pause pulse is applied before entering adjust.
        if (sw.adj) begin
          state_nxt = ST_ADJUST;
          saved_nxt = sw.pause_pulse;
        end else if (sw.pause_pulse) begin
          state_nxt = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (sw.adj) begin
          state_nxt = ST_ADJUST;
          saved_nxt = !sw.pause_pulse;
        end else if (sw.pause_pulse) begin
          state_nxt = ST_RUN;
        end
      end
      ST_ADJUST: begin
        saved_nxt = paused_saved ^ sw.pause_pulse;
        if (!sw.adj) begin
          state_nxt = saved_nxt ? ST_PAUSED : ST_RUN;
          phase_nxt = 1'b0;
        end else if (sw.tick_2hz) begin
          phase_nxt = !phase;
        end
      end
      default: begin
        state_nxt = ST_RUN;
        saved_nxt = 1'b0;
        phase_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      paused_saved <= 1'b0;
      phase        <= 1'b0;
      sw.running   <= 1'b1;
      sw.blank     <= 4'b0000;
    end else begin
      state        <= state_nxt;
      paused_saved <= saved_nxt;
      phase        <= phase_nxt;
      sw.running   <= (state_nxt == ST_RUN);
      if ((state_nxt == ST_ADJUST) && phase_nxt) begin
        sw.blank <= sw.sel ? BLANK_SEC : BLANK_MIN;
      end else begin
        sw.blank <= 4'b0000;
      end
    end
  end

  assign sw.state = state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with hand-computed mm:ss expectations.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stopwatch_if sw();

  stopwatch_ctrl #(.MAX_MIN(59), .MAX_SEC(59)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw.slave)
  );

  logic [15:0] digits;
  assign digits = {sw.min_1, sw.min_0, sw.sec_1, sw.sec_0};

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag, input logic [15:0] exp_digits,
                              input state_t exp_state, input logic [3:0] exp_blank);
    check({tag, "_digits"}, digits, exp_digits);
    check({tag, "_state"}, 16'(sw.state), 16'(exp_state));
    check({tag, "_running"}, 16'(sw.running), 16'(exp_state == ST_RUN));
    check({tag, "_blank"}, 16'(sw.blank), 16'(exp_blank));
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick1(input int n);
    for (int i = 0; i < n; i++) begin
      sw.tick_1hz = 1'b1;
      step();
      sw.tick_1hz = 1'b0;
      step();
    end
  endtask

  task automatic tick2();
    sw.tick_2hz = 1'b1;
    step();
    sw.tick_2hz = 1'b0;
  endtask

  task automatic pause();
    sw.pause_pulse = 1'b1;
    step();
    sw.pause_pulse = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sw.tick_1hz    = 1'b0;
    sw.tick_2hz    = 1'b0;
    sw.pause_pulse = 1'b0;
    sw.sel         = 1'b0;
    sw.adj         = 1'b0;

    do_reset();
    check_status("reset", 16'h0000, ST_RUN, 4'b0000);

    // 65 seconds -> 01:05, running throughout
    for (int i = 0; i < 65; i++) begin
      tick1(1);
      check("run_level", 16'(sw.running), 16'd1);
    end
    check_status("t65", 16'h0105, ST_RUN, 4'b0000);

    // advance to 59:59 (3599 s total), then wrap
    tick1(3599 - 65);
    check("preload_5959", digits, 16'h5959);
    sw.tick_1hz = 1'b1;
    step();
    sw.tick_1hz = 1'b0;
    check_status("wrap_0000", 16'h0000, ST_RUN, 4'b0000);

    // pause at 00:03, ticks ignored, resume
    tick1(3);
    pause();
    check_status("paused", 16'h0003, ST_PAUSED, 4'b0000);
    tick1(10);
    check_status("pause_hold", 16'h0003, ST_PAUSED, 4'b0000);
    pause();
    check("resumed", 16'(sw.running), 16'd1);
    tick1(2);
    check("resume_0005", digits, 16'h0005);

    // adjust seconds from 00:58: 59, 00 (no carry), 01
    tick1(53);
    check("pre_adj_0058", digits, 16'h0058);
    sw.sel = 1'b1;
    sw.adj = 1'b1;
    step();
    check_status("adj_enter", 16'h0058, ST_ADJUST, 4'b0000);
    tick1(1);
    check("adj_ignore_1hz", digits, 16'h0058);
    tick2();
    check_status("adj_t1", 16'h0059, ST_ADJUST, 4'b0011);
    step();
    tick2();
    check_status("adj_t2", 16'h0000, ST_ADJUST, 4'b0000);
    tick2();
    check_status("adj_t3", 16'h0001, ST_ADJUST, 4'b0011);
    sw.sel = 1'b0;
    step();
    check("sel_swap_blank", 16'(sw.blank), 16'(4'b1100));
    sw.adj = 1'b0;
    step();
    check_status("adj_exit_run", 16'h0001, ST_RUN, 4'b0000);

    // paused at 12:00, adjust minutes, toggle saved state inside adjust
    tick1(720 - 1);
    check("pre_1200", digits, 16'h1200);
    pause();
    sw.sel = 1'b0;
    sw.adj = 1'b1;
    step();
    check_status("adj_from_pause", 16'h1200, ST_ADJUST, 4'b0000);
    pause();
    tick2();
    check_status("adj_min", 16'h1300, ST_ADJUST, 4'b1100);
    sw.adj = 1'b0;
    step();
    check_status("adj_exit_toggled", 16'h1300, ST_RUN, 4'b0000);

    // same-cycle tick + pause in RUN at 00:09
    do_reset();
    tick1(9);
    check("pre_0009", digits, 16'h0009);
    sw.tick_1hz    = 1'b1;
    sw.pause_pulse = 1'b1;
    step();
    sw.tick_1hz    = 1'b0;
    sw.pause_pulse = 1'b0;
    check_status("tick_pause", 16'h0010, ST_PAUSED, 4'b0000);

    // reset in the middle of adjust
    sw.sel = 1'b0;
    sw.adj = 1'b1;
    step();
    tick2();
    check_status("pre_rst_adj", 16'h0110, ST_ADJUST, 4'b1100);
    rst = 1'b1;
    step();
    check_status("rst_in_adj", 16'h0000, ST_RUN, 4'b0000);
    rst    = 1'b0;
    sw.adj = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
